// File: rtl/z16_fetch_unit_if.sv
// Z16 fetch bundle: instruction-memory port, decode handshake and fetch control.
interface z16_fetch_unit_if;
  logic [15:0] o_imem_addr;
  logic [15:0] i_imem_instr;
  logic [15:0] o_instr;
  logic [15:0] o_pc;
  logic        o_valid;
  logic        i_ready;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        i_halt;
  logic        o_halted;
  logic        o_misalign;

  // Fetch unit side.
  modport master (
    output o_imem_addr,
    input  i_imem_instr,
    output o_instr,
    output o_pc,
    output o_valid,
    input  i_ready,
    input  i_redirect,
    input  i_redirect_pc,
    input  i_halt,
    output o_halted,
    output o_misalign
  );

  // Memory/decode/control side.
  modport slave (
    input  o_imem_addr,
    output i_imem_instr,
    input  o_instr,
    input  o_pc,
    input  o_valid,
    output i_ready,
    output i_redirect,
    output i_redirect_pc,
    output i_halt,
    input  o_halted,
    input  o_misalign
  );
endinterface

// File: rtl/z16_fetch_unit.sv
// Z16 instruction fetch: owns the PC, reads the combinational IMEM and holds one
// fetched instruction in an output slot offered to decode via valid/ready.
module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  z16_fetch_unit_if.master bus
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  // Bit 0 of the reset PC is forced low so the fetch address is always aligned.
  localparam logic [15:0] ResetPcAligned = {RESET_PC[15:1], 1'b0};

  state_e      r_state;
  logic [15:0] r_f_pc;
  logic [15:0] r_instr;
  logic [15:0] r_pc;
  logic        r_valid;
  logic        r_misalign;

  state_e      w_state_next;
  logic [15:0] w_f_pc_next;
  logic [15:0] w_instr_next;
  logic [15:0] w_pc_next;
  logic        w_valid_next;
  logic        w_misalign_next;
  logic        w_slot_free;

  assign w_slot_free = !r_valid || bus.i_ready;

  // State and slot registers; reset is asynchronous so outputs clear immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StRun;
      r_f_pc     <= ResetPcAligned;
      r_instr    <= 16'h0000;
      r_pc       <= 16'h0000;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_f_pc     <= w_f_pc_next;
      r_instr    <= w_instr_next;
      r_pc       <= w_pc_next;
      r_valid    <= w_valid_next;
      r_misalign <= w_misalign_next;
    end
  end

  // Next-state logic: redirect beats halt beats fetch; HALT only drains the slot.
  always_comb begin
    w_state_next    = r_state;
    w_f_pc_next     = r_f_pc;
    w_instr_next    = r_instr;
    w_pc_next       = r_pc;
    w_valid_next    = r_valid;
    w_misalign_next = 1'b0;

    if (bus.i_redirect) begin
      // Flush the slot; a same-cycle accept has already completed its transfer.
      w_f_pc_next     = {bus.i_redirect_pc[15:1], 1'b0};
      w_valid_next    = 1'b0;
      w_state_next    = StRun;
      w_misalign_next = bus.i_redirect_pc[0];
    end else begin
      unique case (r_state)
        StRun: begin
          if (bus.i_halt) begin
            w_state_next = StHalt;
          end
          // The halting cycle still captures one instruction if the slot is free.
          if (w_slot_free) begin
            w_instr_next = bus.i_imem_instr;
            w_pc_next    = r_f_pc;
            w_valid_next = 1'b1;
            w_f_pc_next  = r_f_pc + 16'd2;
          end
        end
        StHalt: begin
          if (r_valid && bus.i_ready) begin
            w_valid_next = 1'b0;
          end
        end
        default: begin
          w_state_next = StRun;
        end
      endcase
    end
  end

  assign bus.o_imem_addr = r_f_pc;
  assign bus.o_instr     = r_instr;
  assign bus.o_pc        = r_pc;
  assign bus.o_valid     = r_valid;
  assign bus.o_halted    = (r_state == StHalt);
  assign bus.o_misalign  = r_misalign;

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Directed bench for z16_fetch_unit; IMEM model returns addr ^ 16'hA5A5.
module tb_z16_fetch_unit;

  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_pass;

  z16_fetch_unit_if bus ();

  z16_fetch_unit #(
    .RESET_PC (16'h0000)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  assign bus.i_imem_instr = bus.o_imem_addr ^ 16'hA5A5;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [15:0] pc,
                            input logic [15:0] ins, input logic [15:0] addr);
    check({tag, ".valid"}, {15'd0, bus.o_valid}, {15'd0, v});
    check({tag, ".pc"}, bus.o_pc, pc);
    check({tag, ".instr"}, bus.o_instr, ins);
    check({tag, ".addr"}, bus.o_imem_addr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    i_rst_n           = 1'b0;
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 16'h0000;
    bus.i_halt        = 1'b0;
    #2;
    check_slot("rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    check("rst.halted", {15'd0, bus.o_halted}, 16'd0);
    check("rst.misalign", {15'd0, bus.o_misalign}, 16'd0);
    #10;
    i_rst_n = 1'b1;

    // Stream
    step(); check_slot("s0", 1'b1, 16'h0000, 16'hA5A5, 16'h0002);
    step(); check_slot("s1", 1'b1, 16'h0002, 16'hA5A7, 16'h0004);
    step(); check_slot("s2", 1'b1, 16'h0004, 16'hA5A1, 16'h0006);

    // Backpressure for three cycles
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_slot("bp", 1'b1, 16'h0004, 16'hA5A1, 16'h0006);
    end
    bus.i_ready = 1'b1;
    step(); check_slot("bp.rel", 1'b1, 16'h0006, 16'hA5A3, 16'h0008);

    // Misaligned redirect alongside an accepted transfer
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 16'h0031;
    step();
    bus.i_redirect = 1'b0;
    check("rd.valid", {15'd0, bus.o_valid}, 16'd0);
    check("rd.addr", bus.o_imem_addr, 16'h0030);
    check("rd.misalign", {15'd0, bus.o_misalign}, 16'd1);
    step(); check_slot("rd.tgt", 1'b1, 16'h0030, 16'hA595, 16'h0032);
    check("rd.misalign_clr", {15'd0, bus.o_misalign}, 16'd0);

    // Halt: one more capture, then drain
    bus.i_halt = 1'b1;
    step();
    bus.i_halt  = 1'b0;
    bus.i_ready = 1'b0;
    check_slot("h0", 1'b1, 16'h0032, 16'hA597, 16'h0034);
    check("h0.halted", {15'd0, bus.o_halted}, 16'd1);
    for (int i = 0; i < 2; i++) begin
      step(); check_slot("h.stall", 1'b1, 16'h0032, 16'hA597, 16'h0034);
    end
    bus.i_ready = 1'b1;
    step(); check_slot("h.drain", 1'b0, 16'h0032, 16'hA597, 16'h0034);
    step(); check_slot("h.idle", 1'b0, 16'h0032, 16'hA597, 16'h0034);
    check("h.halted", {15'd0, bus.o_halted}, 16'd1);

    // Redirect with halt: redirect wins, fetch resumes
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 16'h0100;
    bus.i_halt        = 1'b1;
    step();
    bus.i_redirect = 1'b0;
    bus.i_halt     = 1'b0;
    check("rh.halted", {15'd0, bus.o_halted}, 16'd0);
    check("rh.valid", {15'd0, bus.o_valid}, 16'd0);
    check("rh.addr", bus.o_imem_addr, 16'h0100);
    check("rh.misalign", {15'd0, bus.o_misalign}, 16'd0);
    step(); check_slot("rh.tgt", 1'b1, 16'h0100, 16'hA4A5, 16'h0102);

    // Wrap-around
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 16'hFFFC;
    step();
    bus.i_redirect = 1'b0;
    check("w.addr", bus.o_imem_addr, 16'hFFFC);
    step(); check_slot("w0", 1'b1, 16'hFFFC, 16'h5A59, 16'hFFFE);
    step(); check_slot("w1", 1'b1, 16'hFFFE, 16'h5A5B, 16'h0000);
    step(); check_slot("w2", 1'b1, 16'h0000, 16'hA5A5, 16'h0002);

    // Asynchronous reset during a stall
    bus.i_ready = 1'b0;
    step(); check_slot("ar.pre", 1'b1, 16'h0000, 16'hA5A5, 16'h0002);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_slot("ar", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    check("ar.halted", {15'd0, bus.o_halted}, 16'd0);
    #10;
    i_rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
